// File: rtl/tx_gcl_ctrl.sv
// Time-aware gate control list sequencer for one TX egress port.
// Steps a programmable list of {gate vector, dwell} entries and falls back to the admin gate vector when not running.
`timescale 1ns/1ps
module tx_gcl_ctrl #(
    parameter int PORT_FIFO_PRI_NUM = 8,
    parameter int GCL_DEPTH         = 16,
    parameter int INTERVAL_W        = 20,
    localparam int AW               = $clog2(GCL_DEPTH),
    localparam int LW               = AW + 1
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_gate_enable,
    input  logic [PORT_FIFO_PRI_NUM-1:0] i_admin_gate_states,
    input  logic [LW-1:0]                i_gcl_len,
    input  logic                         i_gcl_wr_en,
    input  logic [AW-1:0]                i_gcl_wr_addr,
    input  logic [PORT_FIFO_PRI_NUM-1:0] i_gcl_wr_state,
    input  logic [INTERVAL_W-1:0]        i_gcl_wr_interval,
    input  logic                         i_cycle_start,
    output logic [PORT_FIFO_PRI_NUM-1:0] o_ControlList_state,
    output logic [AW-1:0]                o_gcl_index,
    output logic                         o_cycle_done,
    output logic                         o_cfg_err
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_START,
        ST_RUN
    } state_t;

    localparam logic [LW-1:0]         LEN_MAX  = LW'(GCL_DEPTH);
    localparam logic [INTERVAL_W-1:0] INTV_ONE = INTERVAL_W'(1);

    logic [PORT_FIFO_PRI_NUM-1:0] r_state_mem [GCL_DEPTH];
    logic [INTERVAL_W-1:0]        r_intv_mem  [GCL_DEPTH];

    state_t                       r_fsm;
    logic [INTERVAL_W-1:0]        r_cnt;
    logic [AW-1:0]                r_index;
    logic [PORT_FIFO_PRI_NUM-1:0] r_out;
    logic                         r_done;
    logic                         r_cfg_err;

    state_t                       w_fsm_nxt;
    logic [INTERVAL_W-1:0]        w_cnt_nxt;
    logic [AW-1:0]                w_idx_nxt;
    logic [PORT_FIFO_PRI_NUM-1:0] w_out_nxt;
    logic                         w_done_nxt;
    logic                         w_len_legal;
    logic                         w_last;
    logic                         w_load;
    logic [AW-1:0]                w_ld_addr;
    logic [INTERVAL_W-1:0]        w_ld_intv;

    assign w_len_legal = (i_gcl_len != '0) && (i_gcl_len <= LEN_MAX);
    // Shrinking the length below the current index also wraps at the next advance.
    assign w_last      = ({1'b0, r_index} + LW'(1)) >= i_gcl_len;

    // NOTE: the list is a register array, so it gets a real reset value; a RAM-based list would not.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            for (int i = 0; i < GCL_DEPTH; i++) begin
                r_state_mem[i] <= '0;
                r_intv_mem[i]  <= INTV_ONE;
            end
        end else if (i_gcl_wr_en) begin
            r_state_mem[i_gcl_wr_addr] <= i_gcl_wr_state;
            r_intv_mem[i_gcl_wr_addr]  <= i_gcl_wr_interval;
        end
    end

    // NOTE: every combinational output is defaulted first so no path can infer a latch.
    always_comb begin
        w_fsm_nxt  = r_fsm;
        w_cnt_nxt  = r_cnt;
        w_idx_nxt  = r_index;
        w_out_nxt  = r_out;
        w_done_nxt = 1'b0;
        w_load     = 1'b0;
        w_ld_addr  = '0;

        if (!i_gate_enable || !w_len_legal) begin
            w_fsm_nxt = ST_IDLE;
            w_cnt_nxt = '0;
            w_idx_nxt = '0;
            w_out_nxt = i_admin_gate_states;
        end else begin
            unique case (r_fsm)
                ST_IDLE: begin
                    w_fsm_nxt = ST_WAIT_START;
                    w_out_nxt = i_admin_gate_states;
                end
                ST_WAIT_START: begin
                    w_out_nxt = i_admin_gate_states;
                    if (i_cycle_start) begin
                        w_fsm_nxt = ST_RUN;
                        w_load    = 1'b1;
                    end
                end
                ST_RUN: begin
                    if (i_cycle_start) begin
                        w_load = 1'b1;
                    end else if (r_cnt <= INTV_ONE) begin
                        w_load     = 1'b1;
                        w_done_nxt = w_last;
                        w_ld_addr  = w_last ? '0 : r_index + AW'(1);
                    end else begin
                        w_cnt_nxt = r_cnt - INTV_ONE;
                    end
                end
                default: w_fsm_nxt = ST_IDLE;
            endcase
        end

        // The array read sees pre-write contents, so a same-cycle rewrite lands on the next load.
        w_ld_intv = r_intv_mem[w_ld_addr];
        if (w_load) begin
            w_idx_nxt = w_ld_addr;
            w_out_nxt = r_state_mem[w_ld_addr];
            w_cnt_nxt = (w_ld_intv == '0) ? INTV_ONE : w_ld_intv;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_fsm     <= ST_IDLE;
            r_cnt     <= '0;
            r_index   <= '0;
            r_out     <= '1;
            r_done    <= 1'b0;
            r_cfg_err <= 1'b0;
        end else begin
            r_fsm     <= w_fsm_nxt;
            r_cnt     <= w_cnt_nxt;
            r_index   <= w_idx_nxt;
            r_out     <= w_out_nxt;
            r_done    <= w_done_nxt;
            r_cfg_err <= i_gate_enable & ~w_len_legal;
        end
    end

    assign o_ControlList_state = r_out;
    assign o_gcl_index         = r_index;
    assign o_cycle_done        = r_done;
    assign o_cfg_err           = r_cfg_err;

endmodule

// File: doc/tx_gcl_ctrl.md
# tx_gcl_ctrl

Time-aware gate control list (IEEE 802.1Qbv style) sequencer for one egress port of the TSN switch TX MAC. It holds a programmable list of gate-state entries, each with a dwell interval in clock cycles, and steps through it cyclically. It drives the per-priority open/closed vector consumed by the downstream QoS scheduling stage (`i_ControlList_state`). When gating is disabled or misconfigured, it falls back to the admin gate states.

## Interface
- PORT_FIFO_PRI_NUM, 8, number of priority queues; width of each gate-state vector.
- GCL_DEPTH, 16, number of gate control list entries (power of two, ≥2).
- INTERVAL_W, 20, width of the per-entry interval in clock cycles.
- i_clk  in  1  250 MHz clock.
- i_rst  in  1  asynchronous, active-low reset.
- i_gate_enable  in  1  1 = run the list; 0 = drive admin states.
- i_admin_gate_states  in  PORT_FIFO_PRI_NUM  gate vector used when not running.
- i_gcl_len  in  $clog2(GCL_DEPTH)+1  active entry count, legal range 1..GCL_DEPTH.
- i_gcl_wr_en  in  1  one-cycle write strobe for one list entry.
- i_gcl_wr_addr  in  $clog2(GCL_DEPTH)  entry index to write.
- i_gcl_wr_state  in  PORT_FIFO_PRI_NUM  gate vector for the entry; bit i = 1 means queue i is open.
- i_gcl_wr_interval  in  INTERVAL_W  dwell time for the entry in cycles.
- i_cycle_start  in  1  one-cycle pulse from the time base that starts or resynchronises a cycle.
- o_ControlList_state  out  PORT_FIFO_PRI_NUM  current gate vector, registered.
- o_gcl_index  out  $clog2(GCL_DEPTH)  index of the active entry.
- o_cycle_done  out  1  one-cycle pulse when the last entry expires.
- o_cfg_err  out  1  level: enabled with `i_gcl_len` equal to 0 or greater than GCL_DEPTH.

## Operation
- **Storage:** GCL_DEPTH × (PORT_FIFO_PRI_NUM + INTERVAL_W) register array.
  - Written on `i_gcl_wr_en`; writes are accepted in every state.
  - Reset clears state bits to 0 and sets intervals to 1.
- **FSM states:** IDLE, WAIT_START, RUN.
  - IDLE: outputs admin states. Goes to WAIT_START when `i_gate_enable`=1 and the configuration is legal.
  - WAIT_START: outputs admin states. On `i_cycle_start`, loads entry 0 and goes to RUN.
  - RUN:
    - A down-counter is loaded with the entry interval; an interval of 0 is treated as 1.
    - When the counter equals 1, load entry (index+1).
    - If index = `i_gcl_len`−1, wrap to 0 and pulse `o_cycle_done`.
  - From any state: `i_gate_enable`=0 or an illegal length forces IDLE.
  - In RUN, `i_cycle_start` restarts at entry 0 regardless of the counter. It has priority over a normal advance or wrap; in that case `o_cycle_done` is not pulsed.
- **Table read/write collision:** an entry load reads array contents as they were before any same-cycle write. A rewrite therefore takes effect the next time that entry is loaded.
- **Length change in RUN:** `i_gcl_len` is sampled at each advance. If the current index is ≥ the new length−1 at an advance, wrap to 0 with an `o_cycle_done` pulse.
- **Admin states in IDLE/WAIT_START:** `o_ControlList_state` tracks `i_admin_gate_states` with one register stage.
- **`o_cfg_err`:** registered, combinational on `i_gate_enable` & illegal length; does not depend on FSM state.

## Timing
- **Reset values:**
  - `o_ControlList_state` = all ones (all gates open).
  - `o_gcl_index` = 0, `o_cycle_done` = 0, `o_cfg_err` = 0.
  - FSM = IDLE, counter = 0.
- **Cycle start:** `i_cycle_start` at cycle t (WAIT_START or RUN) → entry 0 state on `o_ControlList_state` and `o_gcl_index`=0 at t+1.
- **Dwell:** an entry with interval N (N≥1) is presented for exactly N cycles. Total cycle length is the sum of the intervals, with 0 counted as 1.
- **`o_cycle_done`:** high on the same cycle that entry 0 of the next cycle is first presented.
- **Disable:** `i_gate_enable` falling at t → admin states at t+1, FSM = IDLE.
- **Write latency:** a write at t is visible to any entry load at t+1 or later.
- **Mid-operation reset:** asserting reset returns all outputs to reset values asynchronously. After release, the block waits in IDLE/WAIT_START for a new `i_cycle_start`.

## Test plan
- **Reset:** assert reset → `o_ControlList_state`=8'hFF and `o_gcl_index`=0. Release with enable=0 and admin=8'h0F → output 8'h0F one cycle later.
- **Basic cycle:**
  - Program len=3: {8'h01,5}, {8'h02,3}, {8'h80,2}. Enable, then pulse start.
  - Expect 01×5, 02×3, 80×2, then 01 again with `o_cycle_done` on that cycle.
  - Period is 10 cycles, repeating.
- **Resync:** during entry 1 of the basic cycle, pulse `i_cycle_start` → entry 0 (8'h01) on the next cycle, full 5-cycle dwell, no `o_cycle_done`.
- **Zero interval and live rewrite:**
  - Set entry 1 interval to 0 → 8'h02 is held for 1 cycle.
  - Rewrite entry 0 to {8'hFE,4} while entry 0 is active → current dwell unchanged; the next cycle shows FE×4.
- **Config error:**
  - len=0 with enable=1 → `o_cfg_err`=1, output = admin states, FSM held in IDLE.
  - Restore len=3 → WAIT_START, resumes on the next start pulse.
- **Disable mid-run:** drop enable during entry 2 → admin states next cycle. Re-enable → no gating output change until `i_cycle_start`.
